// File: rtl/instr_fetch.sv
// ============================================================================
// instr_fetch -- multicycle instruction fetch stage feeding instr_decoder.
//
// Holds the program counter, issues one word read per instruction on a
// valid/ready instruction-memory port, registers the returned word and hands
// it to the decoder with a one-cycle ce pulse. It then waits for the execute
// side to retire the instruction. On retire the PC advances to PC+4 or to a
// redirect target, and the retired-instruction counter increments.
//
// Handshake semantics (both memory channels): a transfer happens on a rising
// edge where the sender's valid and the receiver's ready are both high.
// imem_req_valid stays high, with imem_addr stable, until imem_req_ready is
// seen. There is no response-side ready: the fetch stage always accepts
// imem_rsp_valid while in WAIT, and ignores it in every other state. At most
// one request is outstanding at any time.
//
// Optional feature (macro IFETCH_MISALIGN_TRAP_EN):
//   defined   - a retire that redirects to a non-word-aligned target moves to
//               FAULT, keeps the PC, still counts the instruction, and sets
//               fault. Only rst leaves FAULT.
//   undefined - redirect targets have bits [1:0] forced to zero. FAULT cannot
//               be reached and fault is tied low.
//
// Parameters:
//   RESET_PC        PC loaded on reset (must be word-aligned)
// Ports:
//   clk             clock, all state updates on the rising edge
//   rst             synchronous active-high reset
//   imem_req_valid  fetch request valid (high exactly in REQ)
//   imem_req_ready  memory accepts the request
//   imem_addr       fetch address (same as pc_out)
//   imem_rsp_valid  read data valid
//   imem_rsp_data   read data
//   instr           registered instruction word for the decoder
//   ce              decode enable, one-cycle pulse per fetched instruction
//   pc_out          PC of the instruction held in instr
//   retire          execute side finished the current instruction
//   redirect_valid  qualifies redirect_pc; only looked at together with retire
//   redirect_pc     next PC when redirecting
//   fault           sticky misaligned-redirect flag
//   instret         retired-instruction counter (wraps at 32 bits)
//   state_dbg       current FSM state encoding, for observation
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] instr,
    output logic        ce,
    output logic [31:0] pc_out,
    input  logic        retire,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fault,
    output logic [31:0] instret,
    output logic [2:0]  state_dbg
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_REQ   = 3'd0,
        ST_WAIT  = 3'd1,
        ST_DEC   = 3'd2,
        ST_EXEC  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instret_q, instret_d;
    logic        retire_fire;
    logic        trap_taken;
    logic [31:0] redirect_target;

    // Retire only has an effect in EXEC; everywhere else it is ignored.
    assign retire_fire = (state_q == ST_EXEC) && retire;

    // Masking the low bits is harmless when the trap is enabled, because a
    // redirect that does not trap is already aligned.
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

`ifdef IFETCH_MISALIGN_TRAP_EN
    assign trap_taken = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign fault      = (state_q == ST_FAULT);
`else
    assign trap_taken = 1'b0;
    assign fault      = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_REQ;
            pc_q      <= RESET_PC;
            instr_q   <= NOP_INSTR;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            instret_q <= instret_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_REQ:   if (imem_req_ready) state_d = ST_WAIT;
            ST_WAIT:  if (imem_rsp_valid) state_d = ST_DEC;
            ST_DEC:   state_d = ST_EXEC;
            ST_EXEC: begin
                if (retire) begin
                    if (trap_taken) state_d = ST_FAULT;
                    else            state_d = ST_REQ;
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_REQ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next values: instruction capture, PC advance, counter
    // ------------------------------------------------------------------
    always_comb begin
        pc_d      = pc_q;
        instr_d   = instr_q;
        instret_d = instret_q;

        if ((state_q == ST_WAIT) && imem_rsp_valid) begin
            instr_d = imem_rsp_data;
        end

        if (retire_fire) begin
            // A trapping retire still counts, but leaves the PC where it was.
            instret_d = instret_q + 32'd1;
            if (!trap_taken) begin
                pc_d = redirect_valid ? redirect_target : (pc_q + 32'd4);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs decoded from state and registers
    // ------------------------------------------------------------------
    always_comb begin
        imem_req_valid = (state_q == ST_REQ);
        ce             = (state_q == ST_DEC);
        imem_addr      = pc_q;
        pc_out         = pc_q;
        instr          = instr_q;
        instret        = instret_q;
        state_dbg      = state_q;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Multicycle instruction fetch stage directly upstream of `instr_decoder`. Holds the program counter and issues one word read per instruction on a valid/ready instruction-memory port. It registers the returned word and presents it to the decoder with a one-cycle `ce` pulse, then waits for the execute side to retire the instruction. On retire it advances the PC, either sequentially or to a redirect target (JAL), and counts retired instructions.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- `clk`  input  1  clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `imem_req_valid`  output  1  fetch request valid.
- `imem_req_ready`  input  1  memory accepts request.
- `imem_addr`  output  32  fetch address (= `pc_out`).
- `imem_rsp_valid`  input  1  read data valid.
- `imem_rsp_data`  input  32  read data.
- `instr`  output  32  registered instruction word to decoder (`instr_t` width).
- `ce`  output  1  decode enable; one-cycle pulse per fetched instruction.
- `pc_out`  output  32  PC of the instruction currently held in `instr`.
- `retire`  input  1  execute finished current instruction.
- `redirect_valid`  input  1  qualifies `redirect_pc`; sampled only with `retire`.
- `redirect_pc`  input  32  next PC when redirecting (`pc_in_sel` = 0 path).
- `fault`  output  1  sticky misaligned-redirect flag (see Configuration).
- `instret`  output  32  retired-instruction counter.

## Operation
- FSM states: REQ, WAIT, DEC, EXEC, FAULT. Reset state is REQ.
- REQ: `imem_req_valid`=1, `imem_addr`=PC. On `imem_req_ready`, go to WAIT. `imem_rsp_valid` is ignored in REQ.
- WAIT: on `imem_rsp_valid`, `instr` <= `imem_rsp_data`, then go to DEC. At most one request is outstanding.
- DEC: `ce`=1 for exactly this cycle; go to EXEC unconditionally.
- EXEC: hold `instr` and `pc_out`. On `retire`:
  - PC <= `redirect_valid` ? `redirect_pc` : PC+4, with the 32-bit add wrapping (32'hFFFF_FFFC + 4 = 0).
  - `instret`++, with the 32-bit counter wrapping.
  - Go to REQ.
- `retire` outside EXEC is ignored: no PC or counter change.
- FAULT: `imem_req_valid`=0, `ce`=0, `fault`=1. Only `rst` exits FAULT.
- Reset values:
  - `imem_req_valid`=1, since the REQ state is combinational.
  - `imem_addr`=`pc_out`=`RESET_PC`.
  - `instr`=32'h0000_0013 (NOP).
  - `ce`=0, `fault`=0, `instret`=0.
- Reset mid-operation (any state) aborts the fetch. Instruction memory shares `rst`, so no stale response arrives after reset.

## Timing
- `instr` and `pc_out` are registered. `ce` and `imem_req_valid` are decoded from state.
- Minimum cycles per instruction is 4, given ready in the first REQ cycle, response the following cycle, and `retire` in the first EXEC cycle:
  - REQ (cycle 0), WAIT (cycle 1), DEC (cycle 2), EXEC (cycle 3), next REQ (cycle 4).
- `instr` is stable from the DEC cycle until the cycle after `retire`.
- `imem_addr` is stable while `imem_req_valid`=1 and ready is low.
- The new PC is visible on `imem_addr` in the cycle after `retire`.
- Simultaneous `rst` and `retire`: reset wins.

## Configuration
- `IFETCH_MISALIGN_TRAP_EN` defined: a retire with `redirect_valid` and `redirect_pc[1:0]`≠0 does the following:
  - goes to FAULT and sets `fault`;
  - leaves PC unchanged;
  - still increments `instret`.
- Undefined:
  - `redirect_pc[1:0]` is forced to 2'b00 when loaded;
  - the FAULT state is unreachable;
  - `fault` is tied to 0.

## Test plan
- Reset, ready=1, response 1 cycle later with data 32'h0000_10B7 -> `ce` pulses in cycle 2, `instr`=32'h0000_10B7, `pc_out`=0. After `retire` in cycle 3, `imem_addr`=4 in cycle 4 and `instret`=1.
- `imem_req_ready` held low 5 cycles -> `imem_addr` constant, no `ce`. After ready, the sequence completes normally.
- Retire with `redirect_valid`=1, `redirect_pc`=32'h0000_0100 -> next `imem_addr`=32'h100. Without redirect from PC 32'hFFFF_FFFC -> next `imem_addr`=0.
- Assert `rst` during WAIT with PC=32'h40 -> next cycle REQ, `imem_addr`=`RESET_PC`, `instret`=0, `ce` not asserted.
- Redirect to 32'h0000_0102:
  - with the macro: `fault`=1, `imem_req_valid`=0 until reset;
  - without the macro: `imem_addr`=32'h100.
- `retire` pulsed in REQ and WAIT -> PC and `instret` unchanged.
